ethernet_mmio_req_adapter: RTL and testbench
============================================

# ethernet_mmio_req_adapter

Request/response front end that sits directly upstream of `ethernet_controller`. It accepts one MMIO request at a time over a valid/ready handshake and converts it into the controller's single-cycle `write_en`/`read_en` strobe protocol. It captures the controller's synchronous read data one cycle after the strobe and returns a registered response over a valid/yumi handshake. It also rejects misaligned or oversized accesses locally, without touching the controller.

## Interface
- `data_width_p`, 32, controller data width; `size_width_lp = BSG_WIDTH(BSG_SAFE_CLOG2(data_width_p/8))`
- `addr_width_p`, 14, controller byte-address width
- `clk_i`  in  1  sole clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `req_v_i`  in  1  request valid
- `req_ready_o`  out  1  adapter can accept a request
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  `addr_width_p`  byte address
- `req_size_i`  in  `size_width_lp`  log2 of the access size in bytes
- `req_data_i`  in  `data_width_p`  write data, right-justified
- `resp_v_o`  out  1  response valid
- `resp_yumi_i`  in  1  response consumed; legal only while `resp_v_o` is high
- `resp_write_o`  out  1  echo of `req_write_i`
- `resp_error_o`  out  1  access was rejected
- `resp_data_o`  out  `data_width_p`  read data, zero-extended; 0 for writes and errors
- `addr_o`  out  `addr_width_p`  to controller `addr_i`
- `write_en_o`  out  1  to controller `write_en_i`
- `read_en_o`  out  1  to controller `read_en_i`
- `op_size_o`  out  `size_width_lp`  to controller `op_size_i`
- `write_data_o`  out  `data_width_p`  to controller `write_data_i`
- `read_data_i`  in  `data_width_p`  from controller `read_data_o`; sync read, valid the cycle after `read_en_o`

## Operation
- FSM states are `IDLE`, `ACCESS`, `CAPTURE` and `RESP`.
- `req_ready_o` equals `(state == IDLE)`. A request is accepted when `req_v_i & req_ready_o`; it is then registered in full (write flag, address, size, data).
- Error check at acceptance: the access is in error if `req_size_i > log2(data_width_p/8)` or if `req_addr_i mod 2^req_size_i != 0`.
  - On error: go `IDLE -> RESP` with `resp_error_o = 1` and `resp_data_o = 0`.
  - No strobe is issued to the controller.
- Good access: go `IDLE -> ACCESS`. In `ACCESS`, exactly one of `write_en_o` or `read_en_o` is high for one cycle.
  - `addr_o` and `op_size_o` come from the registered request.
  - `write_data_o` is the registered data masked to the low `8 << size` bits, upper bits 0.
- Write: `ACCESS -> RESP`.
- Read: `ACCESS -> CAPTURE`. In `CAPTURE`, `read_data_i` is masked to `8 << size` bits and registered into `resp_data_o`; then `CAPTURE -> RESP`.
- `RESP`: `resp_v_o = 1`, and response fields hold stable until `resp_yumi_i`. On `resp_yumi_i`: `RESP -> IDLE`, `resp_v_o` drops next cycle and response fields clear to 0.
- Strobes are combinational from state: outside `ACCESS`, `write_en_o = read_en_o = 0`. `addr_o`, `op_size_o` and `write_data_o` hold the last registered values.
- Only one request is outstanding at a time; no request queueing.

## Timing
- Reset (`reset_n_i` low, asynchronous): state returns to `IDLE` and every output register clears to 0.
  - `req_ready_o` rises on the first edge after deassertion, because it is decoded from `IDLE`.
  - All other outputs are 0.
- Reset mid-operation: the in-flight request is dropped with no response, and strobes fall immediately.
- Accept at edge T:
  - Write: `write_en_o` high in cycle T+1; `resp_v_o` high from T+2.
  - Read: `read_en_o` high in T+1; `read_data_i` sampled at the end of T+2; `resp_v_o` high from T+3.
  - Error: `resp_v_o` high from T+1.
- `resp_yumi_i` in cycle R returns the FSM to `IDLE` at R+1, so the next request is accepted no earlier than R+1.
  - Minimum period is 3 cycles per write and 4 per read when yumi is immediate.
- `resp_v_o` held high with `resp_yumi_i` low stalls indefinitely with no controller activity.
- `resp_yumi_i` while `resp_v_o` is low is illegal; the FSM ignores it.

## Test plan
- Reset: with `reset_n_i` low, all outputs are 0. After release, `req_ready_o = 1` from the first clock edge onward.
- 4-byte write: `addr = 0x0010`, `size = 2`, `data = 0xDEADBEEF`.
  - Required: one-cycle `write_en_o` with `addr_o = 0x10`, `op_size_o = 2`, `write_data_o = 0xDEADBEEF`.
  - Then `resp_v_o`, `resp_write_o = 1`, `resp_error_o = 0`, `resp_data_o = 0`.
- 1-byte read: `addr = 0x0803`, `size = 0`, model returns `0x12345678`.
  - Required: one-cycle `read_en_o`, and `resp_data_o = 0x00000078` at T+3.
- Misaligned access: `addr = 0x0002`, `size = 2`.
  - Required: `resp_error_o = 1` at T+1; `write_en_o` and `read_en_o` never asserted.
- Oversize access: `size = 3` with `data_width_p = 32`. Required: error response and no strobe.
- Backpressure and reset: hold `resp_yumi_i = 0` for 10 cycles; `resp_v_o` and `resp_data_o` stay stable and `req_ready_o = 0`.
  - Then pulse `reset_n_i` low mid-read (in cycle T+1). Required: `read_en_o` drops at once, no response follows, and `IDLE` is reached.

Source files
------------

// File: rtl/ethernet_mmio_req_adapter.sv
// MMIO request/response front end for ethernet_controller: one request in flight,
// converts valid/ready requests into single-cycle controller strobes and returns a registered response.
module ethernet_mmio_req_adapter #(
    parameter  int unsigned data_width_p  = 32,
    parameter  int unsigned addr_width_p  = 14,
    localparam int unsigned lg_bytes_lp   = $clog2(data_width_p / 8),
    localparam int unsigned safe_lg_lp    = (lg_bytes_lp == 0) ? 1 : lg_bytes_lp,
    localparam int unsigned size_width_lp = $clog2(safe_lg_lp + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [addr_width_p-1:0]  req_addr_i,
    input  logic [size_width_lp-1:0] req_size_i,
    input  logic [data_width_p-1:0]  req_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic                     resp_write_o,
    output logic                     resp_error_o,
    output logic [data_width_p-1:0]  resp_data_o,

    output logic [addr_width_p-1:0]  addr_o,
    output logic                     write_en_o,
    output logic                     read_en_o,
    output logic [size_width_lp-1:0] op_size_o,
    output logic [data_width_p-1:0]  write_data_o,
    input  logic [data_width_p-1:0]  read_data_i
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]               state_q,      state_d;
    logic                     ready_q,      ready_d;
    logic                     write_q,      write_d;
    logic [addr_width_p-1:0]  addr_q,       addr_d;
    logic [size_width_lp-1:0] size_q,       size_d;
    logic [data_width_p-1:0]  data_q,       data_d;
    logic                     resp_v_q,     resp_v_d;
    logic                     resp_write_q, resp_write_d;
    logic                     resp_error_q, resp_error_d;
    logic [data_width_p-1:0]  resp_data_q,  resp_data_d;

    logic                     accept;
    logic                     req_err;
    logic [addr_width_p-1:0]  align_mask;

    // Keeps the low (8 << size) bits; shifts of a full word or more yield an all-ones mask.
    function automatic logic [data_width_p-1:0] size_mask(input logic [size_width_lp-1:0] size);
        return ~({data_width_p{1'b1}} << (32'd8 << size));
    endfunction

    assign accept     = req_v_i & ready_q;
    assign align_mask = ~({addr_width_p{1'b1}} << req_size_i);
    assign req_err    = (32'(req_size_i) > lg_bytes_lp) || ((req_addr_i & align_mask) != '0);

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        size_d       = size_q;
        data_d       = data_q;
        resp_v_d     = resp_v_q;
        resp_write_d = resp_write_q;
        resp_error_d = resp_error_q;
        resp_data_d  = resp_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    data_d  = req_data_i & size_mask(req_size_i);
                    if (req_err) begin
                        // Rejected locally: answer immediately, controller never sees it.
                        state_d      = RESP;
                        resp_v_d     = 1'b1;
                        resp_write_d = req_write_i;
                        resp_error_d = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_d      = RESP;
                    resp_v_d     = 1'b1;
                    resp_write_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_data_d  = '0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_v_d     = 1'b1;
                resp_write_d = 1'b0;
                resp_error_d = 1'b0;
                resp_data_d  = read_data_i & size_mask(size_q);
            end
            RESP: begin
                if (resp_yumi_i) begin
                    state_d      = IDLE;
                    resp_v_d     = 1'b0;
                    resp_write_d = 1'b0;
                    resp_error_d = 1'b0;
                    resp_data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            data_q       <= '0;
            resp_v_q     <= 1'b0;
            resp_write_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            data_q       <= data_d;
            resp_v_q     <= resp_v_d;
            resp_write_q <= resp_write_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Strobes decode from the state register so an async reset drops them at once.
    assign write_en_o   = (state_q == ACCESS) &  write_q;
    assign read_en_o    = (state_q == ACCESS) & ~write_q;

    assign req_ready_o  = ready_q;
    assign addr_o       = addr_q;
    assign op_size_o    = size_q;
    assign write_data_o = data_q;
    assign resp_v_o     = resp_v_q;
    assign resp_write_o = resp_write_q;
    assign resp_error_o = resp_error_q;
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_ethernet_mmio_req_adapter.sv
// Directed bench for ethernet_mmio_req_adapter: table-driven transactions plus
// hand-written reset, backpressure and mid-read reset sequences.
module tb_ethernet_mmio_req_adapter;

    logic        clk;
    logic        reset_n;
    logic        req_v;
    logic        req_ready;
    logic        req_write;
    logic [13:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_data;
    logic        resp_v;
    logic        resp_yumi;
    logic        resp_write;
    logic        resp_error;
    logic [31:0] resp_data;
    logic [13:0] addr;
    logic        write_en;
    logic        read_en;
    logic [1:0]  op_size;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] rd_model;

    int n_checks = 0;
    int n_pass   = 0;

    ethernet_mmio_req_adapter dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_v_i      (req_v),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_size_i   (req_size),
        .req_data_i   (req_data),
        .resp_v_o     (resp_v),
        .resp_yumi_i  (resp_yumi),
        .resp_write_o (resp_write),
        .resp_error_o (resp_error),
        .resp_data_o  (resp_data),
        .addr_o       (addr),
        .write_en_o   (write_en),
        .read_en_o    (read_en),
        .op_size_o    (op_size),
        .write_data_o (write_data),
        .read_data_i  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: synchronous read, junk on the bus when not reading.
    always @(posedge clk) read_data <= read_en ? rd_model : 32'hA5A5_A5A5;

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] rd_val;
        logic        exp_err;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        req_write = v.wr;
        req_addr  = v.addr;
        req_size  = v.size;
        req_data  = v.data;
        rd_model  = v.rd_val;
        req_v     = 1'b1;
        tick();
        req_v     = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int lat = 0;
        int n_wen = 0;
        int n_ren = 0;
        int strobe_cyc = 0;
        logic [13:0] s_addr = '0;
        logic [1:0]  s_size = '0;
        logic [31:0] s_wdata = '0;
        int exp_lat;
        chk($sformatf("v%0d ready_before", idx), 32'(req_ready), 32'd1);
        issue(v);
        for (int c = 1; c <= 12; c++) begin
            if (write_en || read_en) begin
                strobe_cyc = c;
                s_addr  = addr;
                s_size  = op_size;
                s_wdata = write_data;
            end
            if (write_en) n_wen++;
            if (read_en)  n_ren++;
            if (resp_v) begin
                lat = c;
                break;
            end
            tick();
        end
        exp_lat = v.exp_err ? 1 : (v.wr ? 2 : 3);
        chk($sformatf("v%0d resp_latency", idx), 32'(lat), 32'(exp_lat));
        chk($sformatf("v%0d write_en_cycles", idx), 32'(n_wen), (!v.exp_err && v.wr) ? 32'd1 : 32'd0);
        chk($sformatf("v%0d read_en_cycles", idx), 32'(n_ren), (!v.exp_err && !v.wr) ? 32'd1 : 32'd0);
        if (!v.exp_err) begin
            chk($sformatf("v%0d strobe_cycle", idx), 32'(strobe_cyc), 32'd1);
            chk($sformatf("v%0d addr_o", idx), 32'(s_addr), 32'(v.addr));
            chk($sformatf("v%0d op_size_o", idx), 32'(s_size), 32'(v.size));
            chk($sformatf("v%0d write_data_o", idx), s_wdata, v.exp_wdata);
        end
        chk($sformatf("v%0d resp_write", idx), 32'(resp_write), 32'(v.wr));
        chk($sformatf("v%0d resp_error", idx), 32'(resp_error), 32'(v.exp_err));
        chk($sformatf("v%0d resp_data", idx), resp_data, v.exp_rdata);
        chk($sformatf("v%0d ready_busy", idx), 32'(req_ready), 32'd0);
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        chk($sformatf("v%0d resp_v_cleared", idx), 32'(resp_v), 32'd0);
        chk($sformatf("v%0d resp_fields_cleared", idx),
            {resp_data[29:0], resp_write, resp_error}, 32'd0);
        chk($sformatf("v%0d ready_after", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        int          lat;
        int          seen;

        vecs[0] = '{1'b1, 14'h0010, 2'd2, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 14'h0803, 2'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h0000_00FF, 32'h0000_0078};
        vecs[2] = '{1'b1, 14'h0002, 2'd2, 32'h1111_1111, 32'h0,         1'b1, 32'h0,         32'h0};
        vecs[3] = '{1'b0, 14'h0000, 2'd3, 32'h0,         32'h5555_5555, 1'b1, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 14'h0006, 2'd1, 32'hCAFE_F00D, 32'h0,         1'b0, 32'h0000_F00D, 32'h0};
        vecs[5] = '{1'b0, 14'h0012, 2'd1, 32'h0,         32'h8765_4321, 1'b0, 32'h0,         32'h0000_4321};
        vecs[6] = '{1'b0, 14'h0100, 2'd2, 32'h0,         32'h0BAD_F00D, 1'b0, 32'h0,         32'h0BAD_F00D};
        vecs[7] = '{1'b0, 14'h0001, 2'd1, 32'h0,         32'h9999_9999, 1'b1, 32'h0,         32'h0};

        reset_n   = 1'b0;
        req_v     = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_data  = '0;
        resp_yumi = 1'b0;
        rd_model  = '0;

        // Reset: every output low, ready rises on the first edge after release.
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp", {26'd0, resp_v, resp_write, resp_error, write_en, read_en, 1'b0}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_ctrl", {16'd0, addr, op_size}, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        tick();
        tick();
        chk("rst_ready_held_low", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(req_ready), 32'd1);

        // Stray yumi while idle is ignored.
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        chk("idle_yumi_ignored", {30'd0, req_ready, resp_v}, 32'd2);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Backpressure: response holds for 10 cycles with no controller activity.
        issue(vecs[6]);
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            if (resp_v) begin
                lat = c;
                break;
            end
            tick();
        end
        chk("bp_resp_latency", 32'(lat), 32'd3);
        held = resp_data;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!resp_v || resp_data !== held || req_ready || write_en || read_en) seen++;
        end
        chk("bp_stable_cycles_bad", 32'(seen), 32'd0);
        chk("bp_data", resp_data, 32'h0BAD_F00D);
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        chk("bp_released", {30'd0, req_ready, resp_v}, 32'd2);

        // Reset during the read strobe cycle drops the request.
        issue(vecs[1]);
        chk("mid_rst_read_en_pre", 32'(read_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read_en_drop", 32'(read_en), 32'd0);
        chk("mid_rst_ready_low", 32'(req_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (resp_v || write_en || read_en) seen++;
        end
        chk("mid_rst_no_activity", 32'(seen), 32'd0);
        chk("mid_rst_idle", 32'(req_ready), 32'd1);

        run_txn(vecs[0], 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
